// File: rtl/cr_sa_core_param_pkg.sv
// cr_sa_paramPKG: shared types and defaults for the statistics aggregator core.
//   sa_mode_e     - per-counter overflow behaviour (wrap or saturate)
//   SA_*_DEF      - default parameter values for the core and its interface
//   sa_sel_valid  - true when an event select index addresses a real event bit
package cr_sa_paramPKG;

  typedef enum logic {
    SA_WRAP = 1'b0,
    SA_SAT  = 1'b1
  } sa_mode_e;

  localparam int SA_N_GROUPS_DEF = 16;
  localparam int SA_GROUP_W_DEF  = 64;
  localparam int SA_N_CNTRS_DEF  = 64;
  localparam int SA_CNT_W_DEF    = 50;

  function automatic logic sa_sel_valid(input int unsigned sel, input int unsigned n_events);
    return sel < n_events;
  endfunction

endpackage

// File: rtl/cr_sa_core_param_if.sv
// cr_sa_core_param_if: event, register and statistics bundle of the aggregator.
//   stat_events        raw event bits, group g at [g*GROUP_W +: GROUP_W]
//   regs_sa_snap       snapshot request level (rising edge acts)
//   regs_sa_clear_live clear request level (rising edge acts)
//   regs_sa_sel/en/sat per-counter select, enable and overflow mode
//   sa_count           live counts
//   sa_snapshot        snapshot values
//   sa_ovf             sticky overflow flags
//   sa_snap_done       one-cycle pulse when snapshots were updated
// With CR_SA_THRESH_EN defined: regs_sa_thresh, sa_thresh_hit, sa_thresh_irq.
// Modports: master = register/event side, slave = aggregator core.
interface cr_sa_core_param_if
  import cr_sa_paramPKG::*;
#(
  parameter int N_GROUPS = SA_N_GROUPS_DEF,
  parameter int GROUP_W  = SA_GROUP_W_DEF,
  parameter int N_CNTRS  = SA_N_CNTRS_DEF,
  parameter int CNT_W    = SA_CNT_W_DEF
) ();

  localparam int N_EV  = N_GROUPS * GROUP_W;
  localparam int SEL_W = $clog2(N_EV);

  logic [N_EV-1:0]          stat_events;
  logic                     regs_sa_snap;
  logic                     regs_sa_clear_live;
  logic [N_CNTRS*SEL_W-1:0] regs_sa_sel;
  logic [N_CNTRS-1:0]       regs_sa_en;
  logic [N_CNTRS-1:0]       regs_sa_sat;
  logic [N_CNTRS*CNT_W-1:0] sa_count;
  logic [N_CNTRS*CNT_W-1:0] sa_snapshot;
  logic [N_CNTRS-1:0]       sa_ovf;
  logic                     sa_snap_done;
`ifdef CR_SA_THRESH_EN
  logic [N_CNTRS*CNT_W-1:0] regs_sa_thresh;
  logic [N_CNTRS-1:0]       sa_thresh_hit;
  logic                     sa_thresh_irq;
`endif

  modport master (
    output stat_events, regs_sa_snap, regs_sa_clear_live, regs_sa_sel, regs_sa_en, regs_sa_sat,
`ifdef CR_SA_THRESH_EN
    output regs_sa_thresh,
    input  sa_thresh_hit, sa_thresh_irq,
`endif
    input  sa_count, sa_snapshot, sa_ovf, sa_snap_done
  );

  modport slave (
    input  stat_events, regs_sa_snap, regs_sa_clear_live, regs_sa_sel, regs_sa_en, regs_sa_sat,
`ifdef CR_SA_THRESH_EN
    input  regs_sa_thresh,
    output sa_thresh_hit, sa_thresh_irq,
`endif
    output sa_count, sa_snapshot, sa_ovf, sa_snap_done
  );

endinterface

// File: rtl/cr_sa_counter_param.sv
// cr_sa_counter_param: one selectable statistics counter.
//   clk, rst   clock, synchronous active-high reset
//   events     registered event vector from the core
//   sel, en    event select and count enable
//   sat        1 = saturate at all-ones, 0 = wrap to zero
//   snap       copy the current count into snapshot
//   clear      restart the count at this cycle's event (lossless)
//   count, snapshot, ovf  live count, snapshot, sticky overflow
// With CR_SA_THRESH_EN defined: thresh input and sticky thresh_hit output.
module cr_sa_counter_param
  import cr_sa_paramPKG::*;
#(
  parameter int N_EV  = 1024,
  parameter int SEL_W = 10,
  parameter int CNT_W = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_EV-1:0]  events,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic             sat,
  input  logic             snap,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] snapshot,
  output logic             ovf
`ifdef CR_SA_THRESH_EN
  ,
  input  logic [CNT_W-1:0] thresh,
  output logic             thresh_hit
`endif
);

  logic             ev_bit;
  logic             ev;
  logic             cnt_max;
  logic [CNT_W-1:0] cnt_nxt;

  // Out-of-range selects read as zero instead of indexing past the vector.
  always_comb begin
    ev_bit = 1'b0;
    if (sa_sel_valid(32'(sel), N_EV)) begin
      ev_bit = events[sel];
    end
  end

  assign ev      = en & ev_bit;
  assign cnt_max = &count;

  // A clear restarts at this cycle's event so nothing is dropped across the boundary.
  always_comb begin
    cnt_nxt = count;
    if (clear) begin
      cnt_nxt = {{(CNT_W-1){1'b0}}, ev};
    end else if (ev) begin
      if (cnt_max) begin
        cnt_nxt = (sa_mode_e'(sat) == SA_SAT) ? count : '0;
      end else begin
        cnt_nxt = count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      snapshot <= '0;
      ovf      <= 1'b0;
    end else begin
      count <= cnt_nxt;
      if (snap) begin
        snapshot <= count;
      end
      if (clear) begin
        ovf <= 1'b0;
      end else if (ev && cnt_max) begin
        ovf <= 1'b1;
      end
    end
  end

`ifdef CR_SA_THRESH_EN
  logic thresh_eq;

  assign thresh_eq = ev && (cnt_nxt == thresh) && (thresh != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      thresh_hit <= 1'b0;
    end else begin
      thresh_hit <= (thresh_hit & ~clear) | thresh_eq;
    end
  end
`endif

endmodule

// File: rtl/cr_sa_core_param.sv
// cr_sa_core_param: statistics aggregator core.
// Registers the raw event vector, turns the snapshot/clear request levels
// into single-cycle pulses, and drives N_CNTRS selectable counters.
//   clk    clock
//   rst    synchronous active-high reset
//   sa_if  cr_sa_core_param_if.slave (events, regs_sa_*, sa_* outputs)
// Optional feature macro: CR_SA_THRESH_EN (per-counter threshold hit flags
// plus a registered sa_thresh_irq). Undefined by default.
module cr_sa_core_param
  import cr_sa_paramPKG::*;
#(
  parameter int N_GROUPS = SA_N_GROUPS_DEF,
  parameter int GROUP_W  = SA_GROUP_W_DEF,
  parameter int N_CNTRS  = SA_N_CNTRS_DEF,
  parameter int CNT_W    = SA_CNT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  cr_sa_core_param_if.slave sa_if
);

  localparam int N_EV  = N_GROUPS * GROUP_W;
  localparam int SEL_W = $clog2(N_EV);

  logic [N_EV-1:0] sa_events;
  logic            regs_sa_snap_r;
  logic            regs_sa_clear_live_r;
  logic            sa_snap;
  logic            sa_clear;
  logic            sa_snap_done_q;

  logic [CNT_W-1:0]         cnt_arr  [N_CNTRS];
  logic [CNT_W-1:0]         snap_arr [N_CNTRS];
  logic                     ovf_arr  [N_CNTRS];
  logic [N_CNTRS*CNT_W-1:0] count_flat;
  logic [N_CNTRS*CNT_W-1:0] snap_flat;
  logic [N_CNTRS-1:0]       ovf_vec;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_events            <= '0;
      regs_sa_snap_r       <= 1'b0;
      regs_sa_clear_live_r <= 1'b0;
      sa_snap              <= 1'b0;
      sa_clear             <= 1'b0;
      sa_snap_done_q       <= 1'b0;
    end else begin
      sa_events            <= sa_if.stat_events;
      regs_sa_snap_r       <= sa_if.regs_sa_snap;
      regs_sa_clear_live_r <= sa_if.regs_sa_clear_live;
      sa_snap              <= sa_if.regs_sa_snap & ~regs_sa_snap_r;
      sa_clear             <= sa_if.regs_sa_clear_live & ~regs_sa_clear_live_r;
      // Aligned with the cycle in which the counters load their snapshots.
      sa_snap_done_q       <= sa_snap;
    end
  end

`ifdef CR_SA_THRESH_EN
  logic               hit_arr [N_CNTRS];
  logic [N_CNTRS-1:0] hit_vec;
  logic               sa_thresh_irq_q;
`endif

  for (genvar i = 0; i < N_CNTRS; i++) begin : g_cntr
    cr_sa_counter_param #(
      .N_EV  (N_EV),
      .SEL_W (SEL_W),
      .CNT_W (CNT_W)
    ) u_cntr (
      .clk        (clk),
      .rst        (rst),
      .events     (sa_events),
      .sel        (sa_if.regs_sa_sel[i*SEL_W +: SEL_W]),
      .en         (sa_if.regs_sa_en[i]),
      .sat        (sa_if.regs_sa_sat[i]),
      .snap       (sa_snap),
      .clear      (sa_clear),
      .count      (cnt_arr[i]),
      .snapshot   (snap_arr[i]),
      .ovf        (ovf_arr[i])
`ifdef CR_SA_THRESH_EN
      ,
      .thresh     (sa_if.regs_sa_thresh[i*CNT_W +: CNT_W]),
      .thresh_hit (hit_arr[i])
`endif
    );
  end

  always_comb begin
    count_flat = '0;
    snap_flat  = '0;
    ovf_vec    = '0;
    for (int i = 0; i < N_CNTRS; i++) begin
      count_flat[i*CNT_W +: CNT_W] = cnt_arr[i];
      snap_flat[i*CNT_W +: CNT_W]  = snap_arr[i];
      ovf_vec[i]                   = ovf_arr[i];
    end
  end

  assign sa_if.sa_count     = count_flat;
  assign sa_if.sa_snapshot  = snap_flat;
  assign sa_if.sa_ovf       = ovf_vec;
  assign sa_if.sa_snap_done = sa_snap_done_q;

`ifdef CR_SA_THRESH_EN
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < N_CNTRS; i++) begin
      hit_vec[i] = hit_arr[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_thresh_irq_q <= 1'b0;
    end else begin
      sa_thresh_irq_q <= |hit_vec;
    end
  end

  assign sa_if.sa_thresh_hit = hit_vec;
  assign sa_if.sa_thresh_irq = sa_thresh_irq_q;
`endif

endmodule
